trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter ADDR_MSTATUS, default 12'h300, mstatus CSR address.
REQ-002 SHALL have parameter ADDR_MEPC, default 12'h341, mepc address; ADDR_MCAUSE 12'h342; ADDR_MTVAL 12'h343.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports in order: clk (in, 1, rising-edge clock), rst (in, 1, synchronous active-high reset).
REQ-004 SHALL have inputs: instr_valid (1, current instr retires this cycle unless stalled); pc (`MXLEN, address of current instr); instr (`MXLEN, raw instr word).
REQ-005 SHALL have decoder inputs: illegal_i (1), ecall_m (1), mret (1).
REQ-006 SHALL have inputs: ext_irq (1, level interrupt request); mstatus_i, mtvec_i, mepc_i (`MXLEN each, current CSR values); meie_i (1, mie.MEIE).
REQ-007 SHALL have outputs: stall (1, freeze PC/regfile/RAM writes); csr_we (1); csr_waddr (12); csr_wdata (`MXLEN); redirect (1, load PC); redirect_pc (`MXLEN); busy (1, FSM not IDLE).

Function
REQ-008 SHALL use states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, RESTORE, REDIR.
REQ-009 SHALL accept an event only in IDLE with instr_valid=1; priority ext_irq&meie_i&mstatus_i[3] > illegal_i > mret > ecall_m (mret wins when decoder also asserts ecall_m).
REQ-010 SHALL drive stall=1 combinationally in the accept cycle and every cycle until REDIR inclusive; stall=0 in IDLE with no event.
REQ-011 SHALL latch at accept: pc, cause (irq 32'h8000000B, illegal 32'd2, ecall 32'd11), tval (instr for illegal, else 0), kind (trap/mret).
REQ-012 Trap path SHALL be IDLE->W_EPC->W_CAUSE->W_TVAL->W_STAT->REDIR->IDLE, one state per cycle, no waits.
REQ-013 W_EPC SHALL write latched pc (bits[1:0] forced 0) to ADDR_MEPC; W_CAUSE cause to ADDR_MCAUSE; W_TVAL tval to ADDR_MTVAL.
REQ-014 W_STAT SHALL write mstatus_i with bit7(MPIE)=mstatus_i[3], bit3(MIE)=0, bits[12:11](MPP)=2'b11, other bits unchanged.
REQ-015 mret path SHALL be IDLE->RESTORE->REDIR->IDLE; RESTORE writes mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11.
REQ-016 csr_we SHALL be 1 exactly in W_EPC, W_CAUSE, W_TVAL, W_STAT, RESTORE; csr_waddr/csr_wdata 0 when csr_we=0.
REQ-017 REDIR SHALL assert redirect=1 for one cycle; trap target: mtvec_i[1:0]=0 -> {mtvec_i[31:2],2'b0}; =1 and interrupt -> base+4*11; mret target mepc_i.
REQ-018 redirect_pc SHALL be 0 when redirect=0; busy=1 in every state except IDLE.
REQ-019 Inputs other than rst, mstatus_i, mtvec_i, mepc_i SHALL be ignored while busy=1; events present then are lost (pipeline is frozen).
REQ-020 Accept-to-redirect latency SHALL be 5 cycles for traps and 2 cycles for mret; next accept possible the cycle after REDIR.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE and clear latched pc/cause/tval/kind, regardless of state.
REQ-022 During and after reset until an accept: stall=0, csr_we=0, csr_waddr=0, csr_wdata=0, redirect=0, redirect_pc=0, busy=0.
REQ-023 Reset mid-sequence SHALL abort with no further CSR writes and no redirect.

Structure
REQ-024 CSR addresses, cause codes and mstatus bit positions SHALL live in shared defs.v alongside ALU ops; MXLEN from defs.v.
REQ-025 SHALL be a single module; the cause/priority encoder is combinational logic inside it, no sub-module.

Verification
REQ-026 illegal_i, pc=32'h100, instr=32'hFFFFFFFF, mtvec_i=32'h200 -> writes mepc=0x100, mcause=2, mtval=0xFFFFFFFF, mstatus MIE=0; redirect_pc=0x200 at accept+5.
REQ-027 ecall_m=1, mret=0, pc=32'h40 -> mcause=11, mtval=0, redirect to mtvec base at accept+5.
REQ-028 mret=1 and ecall_m=1, mstatus_i=32'h80, mepc_i=32'h44 -> RESTORE writes MIE=1 MPIE=1; redirect_pc=0x44 at accept+2; no mepc/mcause writes.
REQ-029 ext_irq=1, meie_i=1, MIE=1, illegal_i=1, mtvec_i=32'h201 -> mcause=0x8000000B, redirect_pc=0x22C.
REQ-030 ext_irq=1 with MIE=0, no other event -> no accept, stall=0.
REQ-031 rst asserted in W_CAUSE -> next cycle IDLE, all outputs 0, no redirect; new ecall accepted normally afterwards.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared CSR, cause-code and FSM definitions for the trap controller
package trap_ctrl_pkg;

  localparam int MXLEN = 32;

  localparam logic [MXLEN-1:0] CAUSE_IRQ_EXT = 32'h8000000B;
  localparam logic [MXLEN-1:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [MXLEN-1:0] CAUSE_ECALL_M = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_W_EPC   = 3'd1;
  localparam logic [2:0] ST_W_CAUSE = 3'd2;
  localparam logic [2:0] ST_W_TVAL  = 3'd3;
  localparam logic [2:0] ST_W_STAT  = 3'd4;
  localparam logic [2:0] ST_RESTORE = 3'd5;
  localparam logic [2:0] ST_REDIR   = 3'd6;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous privilege.
  function automatic logic [MXLEN-1:0] trap_mstatus(input logic [MXLEN-1:0] s);
    logic [MXLEN-1:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [MXLEN-1:0] mret_mstatus(input logic [MXLEN-1:0] s);
    logic [MXLEN-1:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer writing one CSR per cycle
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MTVAL   = 12'h343
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [MXLEN-1:0] pc,
  input  logic [MXLEN-1:0] instr,
  input  logic             illegal_i,
  input  logic             ecall_m,
  input  logic             mret,
  input  logic             ext_irq,
  input  logic [MXLEN-1:0] mstatus_i,
  input  logic [MXLEN-1:0] mtvec_i,
  input  logic [MXLEN-1:0] mepc_i,
  input  logic             meie_i,
  output logic             stall,
  output logic             csr_we,
  output logic [11:0]      csr_waddr,
  output logic [MXLEN-1:0] csr_wdata,
  output logic             redirect,
  output logic [MXLEN-1:0] redirect_pc,
  output logic             busy
);

  logic [2:0]       state;
  logic [MXLEN-1:0] lat_pc;
  logic [MXLEN-1:0] lat_cause;
  logic [MXLEN-1:0] lat_tval;
  logic             lat_mret;

  logic             irq_req;
  logic             accept;
  logic             nxt_mret;
  logic [MXLEN-1:0] nxt_cause;
  logic [MXLEN-1:0] nxt_tval;
  logic [MXLEN-1:0] trap_base;
  logic [MXLEN-1:0] trap_target;

  assign irq_req = ext_irq & meie_i & mstatus_i[MSTATUS_MIE];
  assign accept  = !rst && (state == ST_IDLE) && instr_valid &&
                   (irq_req || illegal_i || mret || ecall_m);

  // Priority encoder: interrupt, then illegal, then mret (beats a co-decoded ecall).
  always_comb begin
    nxt_mret  = 1'b0;
    nxt_cause = '0;
    nxt_tval  = '0;
    if (irq_req) begin
      nxt_cause = CAUSE_IRQ_EXT;
    end else if (illegal_i) begin
      nxt_cause = CAUSE_ILLEGAL;
      nxt_tval  = instr;
    end else if (mret) begin
      nxt_mret  = 1'b1;
    end else begin
      nxt_cause = CAUSE_ECALL_M;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lat_pc    <= '0;
      lat_cause <= '0;
      lat_tval  <= '0;
      lat_mret  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_pc    <= pc;
            lat_cause <= nxt_cause;
            lat_tval  <= nxt_tval;
            lat_mret  <= nxt_mret;
            state     <= nxt_mret ? ST_RESTORE : ST_W_EPC;
          end
        end
        ST_W_EPC:   state <= ST_W_CAUSE;
        ST_W_CAUSE: state <= ST_W_TVAL;
        ST_W_TVAL:  state <= ST_W_STAT;
        ST_W_STAT:  state <= ST_REDIR;
        ST_RESTORE: state <= ST_REDIR;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  assign trap_base   = {mtvec_i[MXLEN-1:2], 2'b00};
  assign trap_target = (mtvec_i[1:0] == 2'b01 && lat_cause[MXLEN-1]) ?
                       trap_base + MXLEN'(44) : trap_base;

  // Reset gates every output so an aborted sequence cannot leak a write or redirect.
  always_comb begin
    stall       = 1'b0;
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    busy        = 1'b0;
    if (!rst) begin
      busy  = (state != ST_IDLE);
      stall = busy || accept;
      case (state)
        ST_W_EPC: begin
          csr_we    = 1'b1;
          csr_waddr = ADDR_MEPC;
          csr_wdata = {lat_pc[MXLEN-1:2], 2'b00};
        end
        ST_W_CAUSE: begin
          csr_we    = 1'b1;
          csr_waddr = ADDR_MCAUSE;
          csr_wdata = lat_cause;
        end
        ST_W_TVAL: begin
          csr_we    = 1'b1;
          csr_waddr = ADDR_MTVAL;
          csr_wdata = lat_tval;
        end
        ST_W_STAT: begin
          csr_we    = 1'b1;
          csr_waddr = ADDR_MSTATUS;
          csr_wdata = trap_mstatus(mstatus_i);
        end
        ST_RESTORE: begin
          csr_we    = 1'b1;
          csr_waddr = ADDR_MSTATUS;
          csr_wdata = mret_mstatus(mstatus_i);
        end
        ST_REDIR: begin
          redirect    = 1'b1;
          redirect_pc = lat_mret ? mepc_i : trap_target;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        illegal_i;
  logic        ecall_m;
  logic        mret;
  logic        ext_irq;
  logic [31:0] mstatus_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        meie_i;
  logic        stall;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .illegal_i(illegal_i), .ecall_m(ecall_m), .mret(mret), .ext_irq(ext_irq),
    .mstatus_i(mstatus_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .meie_i(meie_i),
    .stall(stall), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_events();
    instr_valid = 1'b0;
    illegal_i   = 1'b0;
    ecall_m     = 1'b0;
    mret        = 1'b0;
    ext_irq     = 1'b0;
    meie_i      = 1'b0;
  endtask

  task automatic test_reset();
    clr_events();
    pc = 32'h0; instr = 32'h0; mstatus_i = 32'h0; mtvec_i = 32'h0; mepc_i = 32'h0;
    rst = 1'b1;
    instr_valid = 1'b1; ecall_m = 1'b1;
    step();
    checks++;
    if ({stall, csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, busy} !== '0) begin
      errors++;
      $display("FAIL reset_hold stall=%b we=%b addr=%h data=%h redir=%b rpc=%h busy=%b exp all 0",
               stall, csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, busy);
    end
    clr_events();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({stall, csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, busy} !== '0) begin
      errors++;
      $display("FAIL reset_after stall=%b we=%b redir=%b busy=%b exp all 0", stall, csr_we, redirect, busy);
    end
  endtask

  task automatic test_illegal();
    pc = 32'h100; instr = 32'hFFFFFFFF; mtvec_i = 32'h200; mstatus_i = 32'h8;
    instr_valid = 1'b1; illegal_i = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL ill_accept stall=%b busy=%b we=%b exp 1 0 0", stall, busy, csr_we);
    end
    step(); clr_events();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h341 || csr_wdata !== 32'h100 || stall !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ill_mepc we=%b addr=%h data=%h stall=%b busy=%b exp 1 341 00000100 1 1",
               csr_we, csr_waddr, csr_wdata, stall, busy);
    end
    step();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h342 || csr_wdata !== 32'd2) begin
      errors++;
      $display("FAIL ill_mcause we=%b addr=%h data=%h exp 1 342 00000002", csr_we, csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h343 || csr_wdata !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL ill_mtval we=%b addr=%h data=%h exp 1 343 ffffffff", csr_we, csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h300 || csr_wdata !== 32'h1880 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL ill_mstatus we=%b addr=%h data=%h redir=%b exp 1 300 00001880 0",
               csr_we, csr_waddr, csr_wdata, redirect);
    end
    step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200 || csr_we !== 1'b0 || csr_waddr !== 12'h0 ||
        csr_wdata !== 32'h0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL ill_redir redir=%b rpc=%h we=%b stall=%b exp 1 00000200 0 1",
               redirect, redirect_pc, csr_we, stall);
    end
    step();
    checks++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL ill_idle redir=%b rpc=%h busy=%b stall=%b exp 0 0 0 0", redirect, redirect_pc, busy, stall);
    end
  endtask

  task automatic test_ecall();
    pc = 32'h40; instr = 32'h00000073; mtvec_i = 32'h301; mstatus_i = 32'h0;
    instr_valid = 1'b1; ecall_m = 1'b1;
    step(); clr_events();
    // A new illegal event while busy must be lost.
    instr_valid = 1'b1; illegal_i = 1'b1;
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h40) begin
      errors++;
      $display("FAIL ecall_mepc addr=%h data=%h exp 341 00000040", csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_waddr !== 12'h342 || csr_wdata !== 32'd11) begin
      errors++;
      $display("FAIL ecall_mcause addr=%h data=%h exp 342 0000000b", csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h343 || csr_wdata !== 32'h0) begin
      errors++;
      $display("FAIL ecall_mtval we=%b addr=%h data=%h exp 1 343 00000000", csr_we, csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_wdata !== 32'h1800) begin
      errors++;
      $display("FAIL ecall_mstatus data=%h exp 00001800", csr_wdata);
    end
    step();
    clr_events();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h300) begin
      errors++;
      $display("FAIL ecall_redir redir=%b rpc=%h exp 1 00000300", redirect, redirect_pc);
    end
    step();
  endtask

  task automatic test_mret();
    pc = 32'h90; mstatus_i = 32'h80; mepc_i = 32'h44; mtvec_i = 32'h200;
    instr_valid = 1'b1; mret = 1'b1; ecall_m = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL mret_accept stall=%b exp 1", stall);
    end
    step(); clr_events();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h300 || csr_wdata !== 32'h1888) begin
      errors++;
      $display("FAIL mret_restore we=%b addr=%h data=%h exp 1 300 00001888", csr_we, csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h44 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL mret_redir redir=%b rpc=%h we=%b exp 1 00000044 0", redirect, redirect_pc, csr_we);
    end
    step();
    checks++;
    if (busy !== 1'b0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL mret_idle busy=%b redir=%b exp 0 0", busy, redirect);
    end
  endtask

  task automatic test_irq();
    pc = 32'h500; instr = 32'h1234; mtvec_i = 32'h201; mstatus_i = 32'h8;
    instr_valid = 1'b1; ext_irq = 1'b1; meie_i = 1'b1; illegal_i = 1'b1;
    step(); clr_events();
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h500) begin
      errors++;
      $display("FAIL irq_mepc addr=%h data=%h exp 341 00000500", csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_waddr !== 12'h342 || csr_wdata !== 32'h8000000B) begin
      errors++;
      $display("FAIL irq_mcause addr=%h data=%h exp 342 8000000b", csr_waddr, csr_wdata);
    end
    step();
    checks++;
    if (csr_wdata !== 32'h0) begin
      errors++;
      $display("FAIL irq_mtval data=%h exp 00000000", csr_wdata);
    end
    step();
    checks++;
    if (csr_wdata !== 32'h1880) begin
      errors++;
      $display("FAIL irq_mstatus data=%h exp 00001880", csr_wdata);
    end
    step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h22C) begin
      errors++;
      $display("FAIL irq_redir redir=%b rpc=%h exp 1 0000022c", redirect, redirect_pc);
    end
    step();
  endtask

  task automatic test_irq_masked();
    mstatus_i = 32'h0; instr_valid = 1'b1; ext_irq = 1'b1; meie_i = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL irq_mie0_stall stall=%b exp 0", stall);
    end
    step();
    checks++;
    if (busy !== 1'b0 || csr_we !== 1'b0) begin
      errors++;
      $display("FAIL irq_mie0_busy busy=%b we=%b exp 0 0", busy, csr_we);
    end
    mstatus_i = 32'h8; meie_i = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL irq_meie0 busy=%b stall=%b exp 0 0", busy, stall);
    end
    clr_events();
  endtask

  task automatic test_reset_mid();
    int bad;
    pc = 32'h60; mtvec_i = 32'h200; mstatus_i = 32'h0;
    instr_valid = 1'b1; ecall_m = 1'b1;
    step(); clr_events();
    step();
    checks++;
    if (csr_we !== 1'b1 || csr_waddr !== 12'h342) begin
      errors++;
      $display("FAIL rstmid_pre we=%b addr=%h exp 1 342", csr_we, csr_waddr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_idle stall=%b we=%b addr=%h redir=%b busy=%b exp all 0",
               stall, csr_we, csr_waddr, redirect, busy);
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (redirect !== 1'b0 || csr_we !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmid_quiet bad_cycles=%0d exp 0", bad);
    end
    pc = 32'h70; instr_valid = 1'b1; ecall_m = 1'b1;
    step(); clr_events();
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h70) begin
      errors++;
      $display("FAIL rstmid_newmepc addr=%h data=%h exp 341 00000070", csr_waddr, csr_wdata);
    end
    step(); step(); step(); step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin
      errors++;
      $display("FAIL rstmid_newredir redir=%b rpc=%h exp 1 00000200", redirect, redirect_pc);
    end
    step();
  endtask

  task automatic test_back_to_back();
    mstatus_i = 32'h80; mepc_i = 32'h88; mtvec_i = 32'h400;
    instr_valid = 1'b1; mret = 1'b1;
    step(); clr_events();
    step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h88) begin
      errors++;
      $display("FAIL b2b_redir redir=%b rpc=%h exp 1 00000088", redirect, redirect_pc);
    end
    step();
    pc = 32'h87; instr_valid = 1'b1; ecall_m = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept stall=%b busy=%b exp 1 0", stall, busy);
    end
    step(); clr_events();
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h84) begin
      errors++;
      $display("FAIL b2b_mepc_align addr=%h data=%h exp 341 00000084", csr_waddr, csr_wdata);
    end
    step(); step(); step(); step();
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h400) begin
      errors++;
      $display("FAIL b2b_trapredir redir=%b rpc=%h exp 1 00000400", redirect, redirect_pc);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_ecall();
    test_mret();
    test_irq();
    test_irq_masked();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
